// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package md_pkg;

  localparam int unsigned WIDTH = 32;
  // One radix-2 step per operand bit.
  localparam int unsigned ITERS = WIDTH;

  // MDOpE encodings
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } md_state_e;

  function automatic logic op_is_signed(logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and data bundle between the pipeline/hazard logic and the mul/div unit.
interface ex_muldiv_unit_if;
  import md_pkg::*;

  logic             StartE;
  logic [1:0]       MDOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             WrHiE;
  logic             WrLoE;
  logic             AbortE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             BusyE;
  logic             DoneE;
  logic             DivZero;

  modport master (
    output StartE, MDOpE, SrcAE, SrcBE, WrHiE, WrLoE, AbortE,
    input  HI, LO, BusyE, DoneE, DivZero
  );

  modport slave (
    input  StartE, MDOpE, SrcAE, SrcBE, WrHiE, WrLoE, AbortE,
    output HI, LO, BusyE, DoneE, DivZero
  );

endinterface

// File: rtl/md_iter_core.sv
// Radix-2 iteration datapath: 64-bit accumulator doing one shift-add (mul) or
// restoring shift-subtract (div) step per enabled cycle. Operands are magnitudes.
module md_iter_core
  import md_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,   // seed accumulator with {0, init_i}
  input  logic               step_i,   // perform one iteration
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   init_i,   // multiplier (mul) or dividend (div)
  input  logic [WIDTH-1:0]   opnd_i,   // multiplicand (mul) or divisor (div)
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // One step of each algorithm; select by operation.
  always_comb begin
    // Mul: conditionally add multiplicand into upper half, then shift right with carry.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_i} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Div: shift remainder left by one, trial-subtract; bit WIDTH of diff is the borrow.
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end

    acc_d = acc_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, init_i};
    end else if (step_i) begin
      acc_d = is_div_i ? div_next : mul_next;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
// Parent handles sign magnitudes, the IDLE/RUN/FIX sequencing and HI/LO updates;
// md_iter_core does the per-bit arithmetic.
module ex_muldiv_unit
  import md_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ex_muldiv_unit_if.slave    md
);

  localparam int unsigned CntW = $clog2(ITERS);

  md_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               dz_q, dz_d;       // in-flight op is a divide by zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   raw_a_q, raw_a_d; // unmodified dividend for div-by-zero HI
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic               in_signed, in_div, in_a_neg, in_b_neg, in_dz;
  logic [WIDTH-1:0]   in_a_mag, in_b_mag;
  logic               start_ok;
  logic               core_step;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  // Decode the incoming request and form operand magnitudes.
  always_comb begin
    in_signed = op_is_signed(md.MDOpE);
    in_div    = op_is_div(md.MDOpE);
    in_a_neg  = in_signed & md.SrcAE[WIDTH-1];
    in_b_neg  = in_signed & md.SrcBE[WIDTH-1];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    in_a_mag  = in_a_neg ? -md.SrcAE : md.SrcAE;
    in_b_mag  = in_b_neg ? -md.SrcBE : md.SrcBE;
    in_dz     = in_div && (md.SrcBE == '0);
    start_ok  = (state_q == StIdle) && md.StartE && !md.AbortE;
    core_step = (state_q == StRun) && !md.AbortE;
  end

  md_iter_core u_core (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (start_ok),
    .step_i   (core_step),
    .is_div_i (is_div_q),
    .init_i   (in_div ? in_a_mag : in_b_mag),
    .opnd_i   (opnd_q),
    .acc_o    (acc)
  );

  // Sign-corrected results taken from the finished accumulator.
  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
    quot = (a_neg_q ^ b_neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer next-state and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    unique case (state_q)
      StIdle: begin
        if (md.StartE) begin
          // A start (even a suppressed one) blocks same-cycle mthi/mtlo.
          if (!md.AbortE) begin
            is_div_d  = in_div;
            a_neg_d   = in_a_neg;
            b_neg_d   = in_b_neg;
            dz_d      = in_dz;
            opnd_d    = in_div ? in_b_mag : in_a_mag;
            raw_a_d   = md.SrcAE;
            cnt_d     = '0;
            divzero_d = 1'b0;
            state_d   = in_dz ? StFix : StRun;
          end
        end else begin
          if (md.WrHiE) hi_d = md.SrcAE;
          if (md.WrLoE) lo_d = md.SrcAE;
        end
      end

      StRun: begin
        if (md.AbortE) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(ITERS - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StFix: begin
        state_d = StIdle;
        if (!md.AbortE) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d      = raw_a_q;
            lo_d      = '1;
            divzero_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Sequencer and architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign md.HI      = hi_q;
  assign md.LO      = lo_q;
  assign md.BusyE   = (state_q != StIdle);
  assign md.DoneE   = done_q;
  assign md.DivZero = divzero_q;

endmodule
